// File: rtl/uart_rx_buffer_pkg.sv
// Shared types and constants for the UART receive buffer.
package uart_rx_buffer_pkg;

  localparam int unsigned UART_RX_SHIFT_W    = 9;
  localparam int unsigned UART_MIN_DATA_BITS = 5;
  localparam int unsigned UART_MAX_DATA_BITS = 8;
  localparam int unsigned UART_CFG_BITS_W    = 4;

  // One received character plus its error tags, as stored in the FIFO.
  typedef struct packed {
    logic                          frame_err;
    logic                          parity_err;
    logic [UART_MAX_DATA_BITS-1:0] data;
  } rx_entry_t;

  localparam int unsigned RX_ENTRY_W = $bits(rx_entry_t);

  // Map an out-of-range data-bit setting onto the widest legal frame.
  function automatic logic [UART_CFG_BITS_W-1:0] eff_data_bits(
    input logic [UART_CFG_BITS_W-1:0] bits
  );
    if (bits < UART_CFG_BITS_W'(UART_MIN_DATA_BITS) ||
        bits > UART_CFG_BITS_W'(UART_MAX_DATA_BITS)) begin
      return UART_CFG_BITS_W'(UART_MAX_DATA_BITS);
    end
    return bits;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO holding received entries.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt_q;
  logic             wr_ok;
  logic             rd_ok;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));
  assign count = cnt_q;

  // A pop on an empty FIFO is ignored; a push on a full FIFO only lands if a pop frees a slot.
  always_comb begin
    rd_ok = pop & ~empty;
    wr_ok = push & (~full | rd_ok);
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wdata;
  end

  // Head is presented straight from memory, forced to zero when nothing is queued.
  assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/uart_rx_buffer.sv
// UART receive buffer: captures completed frames, checks parity/stop, queues them for the CPU.
module uart_rx_buffer
  import uart_rx_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rx_data_valid,
  input  logic [8:0]                 rx_shift_data,
  input  logic                       rx_stop,
  input  logic [3:0]                 cfg_data_bits,
  input  logic                       cfg_parity_en,
  input  logic                       cfg_parity_odd,
  input  logic [$clog2(DEPTH):0]     cfg_thresh,
  input  logic                       rd_en,
  output logic                       rd_valid,
  output logic [7:0]                 rd_data,
  output logic                       rd_parity_err,
  output logic                       rd_frame_err,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overrun,
  input  logic                       ovr_clr,
  output logic                       rx_irq
);

  localparam int unsigned SW = UART_RX_SHIFT_W;
  localparam int unsigned NW = UART_CFG_BITS_W;
  localparam int unsigned DW = UART_MAX_DATA_BITS;

  logic          s1_valid;
  logic [SW-1:0] s1_shift;
  logic          s1_stop;
  logic [NW-1:0] s1_bits;
  logic          s1_par_en;
  logic          s1_par_odd;

  logic [NW-1:0] n_eff;
  logic [NW-1:0] shamt;
  logic [SW-1:0] payload;
  logic [SW-1:0] mask;
  logic [SW-1:0] pbit_vec;
  logic [DW-1:0] data_w;
  rx_entry_t     chk_entry;

  logic [RX_ENTRY_W-1:0] head_raw;
  rx_entry_t             head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  drop_c;

  // Snapshot the frame and its configuration so later config writes cannot alter it.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_shift   <= '0;
      s1_stop    <= 1'b0;
      s1_bits    <= '0;
      s1_par_en  <= 1'b0;
      s1_par_odd <= 1'b0;
    end else begin
      s1_valid <= rx_data_valid;
      if (rx_data_valid) begin
        s1_shift   <= rx_shift_data;
        s1_stop    <= rx_stop;
        s1_bits    <= cfg_data_bits;
        s1_par_en  <= cfg_parity_en;
        s1_par_odd <= cfg_parity_odd;
      end
    end
  end

  // Right-align the received bits, split data from parity and tag errors.
  always_comb begin
    chk_entry = '0;
    n_eff     = eff_data_bits(s1_bits);
    shamt     = NW'(SW) - n_eff - {{(NW-1){1'b0}}, s1_par_en};
    payload   = s1_shift >> shamt;
    mask      = (SW'(1) << n_eff) - SW'(1);
    pbit_vec  = payload >> n_eff;
    data_w    = DW'(payload & mask);
    chk_entry.data       = data_w;
    chk_entry.parity_err = s1_par_en & ((^data_w ^ pbit_vec[0]) != s1_par_odd);
    chk_entry.frame_err  = ~s1_stop;
  end

  uart_rx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (RX_ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s1_valid),
    .pop   (rd_en),
    .wdata (chk_entry),
    .rdata (head_raw),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  assign head          = rx_entry_t'(head_raw);
  assign rd_valid      = ~fifo_empty;
  assign rd_data       = head.data;
  assign rd_parity_err = head.parity_err;
  assign rd_frame_err  = head.frame_err;

  // A frame is lost only when the FIFO is full and no pop frees a slot this cycle.
  assign drop_c = s1_valid & fifo_full & ~rd_en;

  // Sticky overrun; a new drop takes priority over a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (drop_c) begin
      overrun <= 1'b1;
    end else if (ovr_clr) begin
      overrun <= 1'b0;
    end
  end

  // Level interrupt, registered from the current occupancy; a zero threshold disables it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_irq <= 1'b0;
    end else begin
      rx_irq <= (cfg_thresh != '0) && (count >= cfg_thresh);
    end
  end

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Scoreboard bench for uart_rx_buffer: directed test-plan cases plus randomized traffic.
module tb_uart_rx_buffer;
  import uart_rx_buffer_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst;
  logic          rx_data_valid;
  logic [8:0]    rx_shift_data;
  logic          rx_stop;
  logic [3:0]    cfg_data_bits;
  logic          cfg_parity_en;
  logic          cfg_parity_odd;
  logic [CW-1:0] cfg_thresh;
  logic          rd_en;
  logic          rd_valid;
  logic [7:0]    rd_data;
  logic          rd_parity_err;
  logic          rd_frame_err;
  logic [CW-1:0] count;
  logic          overrun;
  logic          ovr_clr;
  logic          rx_irq;

  uart_rx_buffer #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_data_valid  (rx_data_valid),
    .rx_shift_data  (rx_shift_data),
    .rx_stop        (rx_stop),
    .cfg_data_bits  (cfg_data_bits),
    .cfg_parity_en  (cfg_parity_en),
    .cfg_parity_odd (cfg_parity_odd),
    .cfg_thresh     (cfg_thresh),
    .rd_en          (rd_en),
    .rd_valid       (rd_valid),
    .rd_data        (rd_data),
    .rd_parity_err  (rd_parity_err),
    .rd_frame_err   (rd_frame_err),
    .count          (count),
    .overrun        (overrun),
    .ovr_clr        (ovr_clr),
    .rx_irq         (rx_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit [7:0] data;
    bit       pe;
    bit       fe;
  } exp_t;

  exp_t in_q[$];    // frames issued, not yet through the check stage
  exp_t fifo_q[$];  // frames the model holds in the FIFO
  bit   m_s1;
  bit   m_ovr;
  bit   m_irq;
  bit   mon_en;
  int   n_tests;
  int   n_fail;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Decode a frame bit by bit: the first received bit sits lowest in the occupied field.
  function automatic exp_t ref_decode(bit [8:0] sh, bit stop, bit [3:0] nb, bit p, bit odd);
    exp_t e;
    int   n;
    int   l;
    int   ones;
    bit   pb;
    n = (nb >= 4'd5 && nb <= 4'd8) ? int'(nb) : 8;
    l = n + int'(p);
    e.data = 8'h00;
    for (int i = 0; i < n; i++) e.data[i] = sh[9 - l + i];
    pb   = p ? sh[8] : 1'b0;
    ones = $countones(e.data) + int'(pb);
    e.pe = p && ((ones % 2 == 1) != odd);
    e.fe = !stop;
    return e;
  endfunction

  // Monitor checks the DUT against the model, then advances the model over the coming edge.
  always @(negedge clk) begin : monitor
    bit   pop;
    bit   acc;
    bit   drop;
    bit   irq_n;
    exp_t e;
    if (mon_en) begin
      check("rd_valid", 32'(rd_valid), 32'(fifo_q.size() != 0));
      check("count", 32'(count), 32'(fifo_q.size()));
      check("overrun", 32'(overrun), 32'(m_ovr));
      check("rx_irq", 32'(rx_irq), 32'(m_irq));
      if (rd_valid && fifo_q.size() != 0) begin
        check("head_data", 32'(rd_data), 32'(fifo_q[0].data));
        check("head_perr", 32'(rd_parity_err), 32'(fifo_q[0].pe));
        check("head_ferr", 32'(rd_frame_err), 32'(fifo_q[0].fe));
      end
    end
    if (rst) begin
      fifo_q.delete();
      in_q.delete();
      m_s1  = 1'b0;
      m_ovr = 1'b0;
      m_irq = 1'b0;
    end else begin
      irq_n = (cfg_thresh != 0) && (fifo_q.size() >= int'(cfg_thresh));
      pop   = rd_en && (fifo_q.size() != 0);
      acc   = 1'b0;
      drop  = 1'b0;
      e     = '{8'h00, 1'b0, 1'b0};
      if (m_s1) begin
        if (in_q.size() == 0) begin
          check("sb_in_q_empty", 32'd0, 32'd1);
        end else begin
          e = in_q.pop_front();
          if (fifo_q.size() < DEPTH || pop) acc = 1'b1;
          else drop = 1'b1;
        end
      end
      if (pop) void'(fifo_q.pop_front());
      if (acc) fifo_q.push_back(e);
      if (drop) m_ovr = 1'b1;
      else if (ovr_clr) m_ovr = 1'b0;
      m_s1  = rx_data_valid;
      m_irq = irq_n;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one frame for one cycle and record its expected entry; config is scrambled afterwards.
  task automatic send(bit [8:0] sh, bit stop, bit [3:0] nb, bit p, bit odd);
    rx_shift_data  = sh;
    rx_stop        = stop;
    cfg_data_bits  = nb;
    cfg_parity_en  = p;
    cfg_parity_odd = odd;
    rx_data_valid  = 1'b1;
    in_q.push_back(ref_decode(sh, stop, nb, p, odd));
    tick();
    rx_data_valid  = 1'b0;
    rx_shift_data  = 9'($urandom);
    rx_stop        = 1'($urandom);
    cfg_data_bits  = 4'($urandom);
    cfg_parity_en  = 1'($urandom);
    cfg_parity_odd = 1'($urandom);
  endtask

  // Test-plan frame: check the head two cycles after the pulse, then pop it.
  task automatic plan_case(string nm, bit [8:0] sh, bit stop, bit [3:0] nb, bit p, bit odd,
                           bit [7:0] d, bit pe, bit fe);
    send(sh, stop, nb, p, odd);
    tick();
    check({nm, "_valid"}, 32'(rd_valid), 32'd1);
    check({nm, "_data"}, 32'(rd_data), 32'(d));
    check({nm, "_perr"}, 32'(rd_parity_err), 32'(pe));
    check({nm, "_ferr"}, 32'(rd_frame_err), 32'(fe));
    check({nm, "_count"}, 32'(count), 32'd1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    bit [7:0] exp_arr[DEPTH];
    int       rd_pct;
    n_tests = 0;
    n_fail  = 0;
    mon_en  = 1'b0;
    rst = 1'b1;
    rx_data_valid = 1'b0;
    rx_shift_data = '0;
    rx_stop = 1'b1;
    cfg_data_bits = 4'd8;
    cfg_parity_en = 1'b0;
    cfg_parity_odd = 1'b0;
    cfg_thresh = '0;
    rd_en = 1'b0;
    ovr_clr = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_irq", 32'(rx_irq), 32'd0);
    check("rst_data", 32'({rd_frame_err, rd_parity_err, rd_data}), 32'd0);
    mon_en = 1'b1;

    plan_case("8N1", 9'h0AA, 1'b1, 4'd8, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0);
    plan_case("8E1_ok", 9'h0A5, 1'b1, 4'd8, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0);
    plan_case("8E1_bad", 9'h1A5, 1'b1, 4'd8, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0);
    plan_case("8O1_bad", 9'h0A5, 1'b1, 4'd8, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0);
    plan_case("7N1", 9'h0AC, 1'b1, 4'd7, 1'b0, 1'b0, 8'h2B, 1'b0, 1'b0);
    plan_case("5N1_ferr", 9'h1F0, 1'b0, 4'd5, 1'b0, 1'b0, 8'h1F, 1'b0, 1'b1);
    plan_case("illegalN", 9'h0AA, 1'b1, 4'd3, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0);

    // Fill past capacity with back-to-back frames; the last one is dropped.
    for (int i = 0; i <= DEPTH; i++) send({8'(i), 1'b0}, 1'b1, 4'd8, 1'b0, 1'b0);
    tick();
    check("fill_overrun", 32'(overrun), 32'd1);
    check("fill_count", 32'(count), 32'(DEPTH));
    rd_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_order", 32'(rd_data), 32'(i));
      tick();
    end
    rd_en = 1'b0;
    check("drain_empty", 32'(rd_valid), 32'd0);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check("ovr_clr", 32'(overrun), 32'd0);

    // Full FIFO: a push and a pop in the same cycle are both taken.
    for (int i = 0; i < DEPTH; i++) send({8'(8'h10 + i), 1'b0}, 1'b1, 4'd8, 1'b0, 1'b0);
    tick();
    check("full_count", 32'(count), 32'(DEPTH));
    send({8'hAA, 1'b0}, 1'b1, 4'd8, 1'b0, 1'b0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    tick();
    check("pp_overrun", 32'(overrun), 32'd0);
    check("pp_count", 32'(count), 32'(DEPTH));
    for (int i = 0; i < DEPTH - 1; i++) exp_arr[i] = 8'(8'h11 + i);
    exp_arr[DEPTH-1] = 8'hAA;
    rd_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check("pp_order", 32'(rd_data), 32'(exp_arr[i]));
      tick();
    end
    rd_en = 1'b0;

    // Threshold interrupt follows occupancy by one cycle.
    cfg_thresh = CW'(3);
    for (int i = 0; i < 3; i++) send(9'(i * 2), 1'b1, 4'd8, 1'b0, 1'b0);
    tick();
    check("irq_count3", 32'(count), 32'd3);
    check("irq_lag", 32'(rx_irq), 32'd0);
    tick();
    check("irq_set", 32'(rx_irq), 32'd1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    tick();
    check("irq_clr", 32'(rx_irq), 32'd0);

    // Reset while a frame sits in the capture stage.
    send(9'h155, 1'b1, 4'd8, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid_count", 32'(count), 32'd0);
    check("rstmid_valid", 32'(rd_valid), 32'd0);
    tick();
    check("rstmid_discard", 32'(count), 32'd0);

    // Randomized traffic with varying read pressure.
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0) rd_pct = int'($urandom_range(10, 90));
      rst     = ($urandom_range(0, 599) == 0);
      ovr_clr = ($urandom_range(0, 19) == 0);
      rd_en   = (int'($urandom_range(0, 99)) < rd_pct);
      if ($urandom_range(0, 49) == 0) cfg_thresh = CW'($urandom_range(0, DEPTH));
      rx_shift_data  = 9'($urandom);
      rx_stop        = ($urandom_range(0, 3) != 0);
      cfg_data_bits  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(5, 8));
      cfg_parity_en  = 1'($urandom);
      cfg_parity_odd = 1'($urandom);
      rx_data_valid  = ($urandom_range(0, 1) == 0);
      if (rx_data_valid)
        in_q.push_back(ref_decode(rx_shift_data, rx_stop, cfg_data_bits,
                                  cfg_parity_en, cfg_parity_odd));
      tick();
    end
    rx_data_valid = 1'b0;
    rst = 1'b0;
    ovr_clr = 1'b0;
    rd_en = 1'b1;
    repeat (DEPTH + 4) tick();
    rd_en = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
